// File: rtl/servo_output_limiter_if.sv
// rtl/servo_output_limiter_if.sv - filter-to-DAC sample path of the servo output limiter
interface servo_output_limiter_if #(
  parameter int SIGNAL_SIZE = 16
);
  logic signed [SIGNAL_SIZE-1:0] signal_in;
  logic signed [SIGNAL_SIZE-1:0] signal_out;
  logic        [1:0]             railed_out;

  modport master (
    output signal_in,
    input  signal_out,
    input  railed_out
  );

  modport slave (
    input  signal_in,
    output signal_out,
    output railed_out
  );
endinterface

// File: rtl/servo_output_limiter.sv
// rtl/servo_output_limiter.sv - clamp to min/max rails, registered railed flags, dwell alarm and rail-entry count
module servo_output_limiter #(
  parameter int SIGNAL_SIZE = 16,
  parameter int DWELL_WIDTH = 24,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          on_in,
  input  logic signed [SIGNAL_SIZE-1:0] min_in,
  input  logic signed [SIGNAL_SIZE-1:0] max_in,
  input  logic        [DWELL_WIDTH-1:0] alarm_cycles_in,
  input  logic                          clear_in,
  servo_output_limiter_if.slave         sig_if,
  output logic                          alarm_out,
  output logic        [COUNT_WIDTH-1:0] rail_count_out
);

  typedef enum logic [1:0] {
    TRACK   = 2'd0,
    RAIL_LO = 2'd1,
    RAIL_HI = 2'd2,
    ALARM   = 2'd3
  } state_t;

  state_t                        state_q, state_d, target_c;
  logic signed [SIGNAL_SIZE-1:0] signal_q, signal_d, clamp_c;
  logic        [1:0]             railed_q, railed_d, railed_c;
  logic        [DWELL_WIDTH-1:0] dwell_q, dwell_d, dwell_inc;
  logic        [COUNT_WIDTH-1:0] count_q, count_d, count_inc;

  // Both rail tests may fire together only when min == max and the input sits on it.
  always_comb begin
    clamp_c  = sig_if.signal_in;
    railed_c = 2'b00;
    if (min_in > max_in) begin
      clamp_c  = min_in;
      railed_c = 2'b11;
    end else begin
      if (sig_if.signal_in >= max_in) begin
        clamp_c     = max_in;
        railed_c[1] = 1'b1;
      end
      if (sig_if.signal_in <= min_in) begin
        clamp_c     = min_in;
        railed_c[0] = 1'b1;
      end
    end
  end

  always_comb begin
    target_c = TRACK;
    if (railed_c[0]) begin
      target_c = RAIL_LO;
    end else if (railed_c[1]) begin
      target_c = RAIL_HI;
    end
  end

  assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
  assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    count_d  = count_q;
    signal_d = on_in ? clamp_c : '0;
    railed_d = on_in ? railed_c : 2'b00;

    if (!on_in) begin
      dwell_d = '0;
      if (state_q != ALARM) begin
        state_d = TRACK;
      end
    end else begin
      case (state_q)
        TRACK, RAIL_LO, RAIL_HI: begin
          if (target_c == TRACK) begin
            state_d = TRACK;
            dwell_d = '0;
          end else begin
            if (target_c == state_q) begin
              dwell_d = dwell_inc;
            end else begin
              dwell_d = DWELL_WIDTH'(1);
              count_d = count_inc;
            end
            state_d = target_c;
            if ((alarm_cycles_in != '0) && (dwell_d == alarm_cycles_in)) begin
              state_d = ALARM;
            end
          end
        end
        ALARM: begin
          state_d = ALARM;
        end
        default: begin
          state_d = TRACK;
        end
      endcase
    end

    // Clear re-derives the state from the live input without counting an entry.
    if (clear_in) begin
      count_d = '0;
      dwell_d = '0;
      state_d = on_in ? target_c : TRACK;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= TRACK;
      signal_q <= '0;
      railed_q <= 2'b00;
      dwell_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      signal_q <= signal_d;
      railed_q <= railed_d;
      dwell_q  <= dwell_d;
      count_q  <= count_d;
    end
  end

  assign sig_if.signal_out = signal_q;
  assign sig_if.railed_out = railed_q;
  assign alarm_out         = (state_q == ALARM);
  assign rail_count_out    = count_q;

endmodule

// File: tb/tb_servo_output_limiter.sv
// tb/tb_servo_output_limiter.sv - directed self-checking bench for servo_output_limiter
module tb_servo_output_limiter;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               on = 1'b1;
  logic signed [15:0] min_v = -16'sd1000;
  logic signed [15:0] max_v = 16'sd1000;
  logic        [23:0] alarm_cycles = 24'd0;
  logic               clear = 1'b0;
  logic               alarm;
  logic        [15:0] rail_count;
  int                 errors = 0;
  int                 checks = 0;

  servo_output_limiter_if #(.SIGNAL_SIZE(16)) bus ();

  servo_output_limiter #(
    .SIGNAL_SIZE(16),
    .DWELL_WIDTH(24),
    .COUNT_WIDTH(16)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .on_in           (on),
    .min_in          (min_v),
    .max_in          (max_v),
    .alarm_cycles_in (alarm_cycles),
    .clear_in        (clear),
    .sig_if          (bus.slave),
    .alarm_out       (alarm),
    .rail_count_out  (rail_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.signal_in = 16'sd0;
    #3;
    checks++; if (bus.signal_out !== 16'sd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", bus.signal_out); end
    checks++; if (bus.railed_out !== 2'b00) begin errors++; $display("FAIL reset_railed got=%b exp=00", bus.railed_out); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
    checks++; if (rail_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", rail_count); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bus.signal_in = 16'sd500;
    step();
    checks++; if (bus.signal_out !== 16'sd500) begin errors++; $display("FAIL basic_out got=%0d exp=500", bus.signal_out); end
    checks++; if (bus.railed_out !== 2'b00) begin errors++; $display("FAIL basic_railed got=%b exp=00", bus.railed_out); end
    checks++; if (rail_count !== 16'd0) begin errors++; $display("FAIL basic_count got=%0d exp=0", rail_count); end
  endtask

  task automatic test_ramp();
    logic signed [15:0] exp_out;
    logic        [1:0]  exp_r;
    for (int s = 990; s <= 1010; s++) begin
      bus.signal_in = 16'(s);
      step();
      exp_out = (s >= 1000) ? 16'sd1000 : 16'(s);
      exp_r   = (s >= 1000) ? 2'b10 : 2'b00;
      checks++; if (bus.signal_out !== exp_out) begin errors++; $display("FAIL ramp_out in=%0d got=%0d exp=%0d", s, bus.signal_out, exp_out); end
      checks++; if (bus.railed_out !== exp_r) begin errors++; $display("FAIL ramp_railed in=%0d got=%b exp=%b", s, bus.railed_out, exp_r); end
    end
    checks++; if (rail_count !== 16'd1) begin errors++; $display("FAIL ramp_count got=%0d exp=1", rail_count); end
  endtask

  task automatic test_alarm();
    bus.signal_in = 16'sd0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (rail_count !== 16'd0) begin errors++; $display("FAIL alarm_preclear_count got=%0d exp=0", rail_count); end
    alarm_cycles = 24'd8;
    bus.signal_in = -16'sd2000;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (alarm !== (k == 8)) begin errors++; $display("FAIL alarm_dwell edge=%0d got=%b exp=%b", k, alarm, (k == 8)); end
    end
    checks++; if (bus.railed_out !== 2'b01) begin errors++; $display("FAIL alarm_railed got=%b exp=01", bus.railed_out); end
    checks++; if (bus.signal_out !== -16'sd1000) begin errors++; $display("FAIL alarm_out got=%0d exp=-1000", bus.signal_out); end
    bus.signal_in = 16'sd0;
    step();
    step();
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_sticky got=%b exp=1", alarm); end
    checks++; if (bus.railed_out !== 2'b00) begin errors++; $display("FAIL alarm_track_railed got=%b exp=00", bus.railed_out); end
    bus.signal_in = 16'sd2000;
    step();
    checks++; if (rail_count !== 16'd1) begin errors++; $display("FAIL alarm_no_count got=%0d exp=1", rail_count); end
    checks++; if (bus.railed_out !== 2'b10) begin errors++; $display("FAIL alarm_track_hi got=%b exp=10", bus.railed_out); end
    bus.signal_in = 16'sd0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_clear got=%b exp=0", alarm); end
    checks++; if (rail_count !== 16'd0) begin errors++; $display("FAIL alarm_clear_count got=%0d exp=0", rail_count); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_r;
    alarm_cycles = 24'd2;
    for (int i = 0; i < 10; i++) begin
      bus.signal_in = (i % 2 == 0) ? 16'sd2000 : -16'sd2000;
      exp_r = (i % 2 == 0) ? 2'b10 : 2'b01;
      step();
      checks++; if (bus.railed_out !== exp_r) begin errors++; $display("FAIL swap_railed i=%0d got=%b exp=%b", i, bus.railed_out, exp_r); end
      checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL swap_alarm i=%0d got=%b exp=0", i, alarm); end
    end
    checks++; if (rail_count !== 16'd10) begin errors++; $display("FAIL swap_count got=%0d exp=10", rail_count); end
  endtask

  task automatic test_invalid_and_off();
    alarm_cycles = 24'd0;
    min_v = 16'sd100;
    max_v = -16'sd100;
    bus.signal_in = 16'sd0;
    step();
    checks++; if (bus.signal_out !== 16'sd100) begin errors++; $display("FAIL invalid_out got=%0d exp=100", bus.signal_out); end
    checks++; if (bus.railed_out !== 2'b11) begin errors++; $display("FAIL invalid_railed got=%b exp=11", bus.railed_out); end
    checks++; if (rail_count !== 16'd10) begin errors++; $display("FAIL invalid_count got=%0d exp=10", rail_count); end
    on = 1'b0;
    step();
    checks++; if (bus.signal_out !== 16'sd0) begin errors++; $display("FAIL off_out got=%0d exp=0", bus.signal_out); end
    checks++; if (bus.railed_out !== 2'b00) begin errors++; $display("FAIL off_railed got=%b exp=00", bus.railed_out); end
    checks++; if (rail_count !== 16'd10) begin errors++; $display("FAIL off_count got=%0d exp=10", rail_count); end
    on = 1'b1;
    step();
    checks++; if (bus.railed_out !== 2'b11) begin errors++; $display("FAIL reon_railed got=%b exp=11", bus.railed_out); end
    checks++; if (rail_count !== 16'd11) begin errors++; $display("FAIL reon_count got=%0d exp=11", rail_count); end
  endtask

  task automatic test_equal_rails();
    logic signed [15:0] ins [3];
    logic        [1:0]  exp_r [3];
    ins[0] = 16'sd50; exp_r[0] = 2'b11;
    ins[1] = 16'sd60; exp_r[1] = 2'b10;
    ins[2] = 16'sd40; exp_r[2] = 2'b01;
    min_v = 16'sd50;
    max_v = 16'sd50;
    for (int i = 0; i < 3; i++) begin
      bus.signal_in = ins[i];
      step();
      checks++; if (bus.signal_out !== 16'sd50) begin errors++; $display("FAIL eq_out in=%0d got=%0d exp=50", ins[i], bus.signal_out); end
      checks++; if (bus.railed_out !== exp_r[i]) begin errors++; $display("FAIL eq_railed in=%0d got=%b exp=%b", ins[i], bus.railed_out, exp_r[i]); end
    end
  endtask

  task automatic test_reset_mid_dwell();
    min_v = -16'sd1000;
    max_v = 16'sd1000;
    alarm_cycles = 24'd8;
    bus.signal_in = 16'sd0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    bus.signal_in = -16'sd2000;
    for (int k = 0; k < 5; k++) step();
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL mid_alarm_early got=%b exp=0", alarm); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.signal_out !== 16'sd0) begin errors++; $display("FAIL mid_rst_out got=%0d exp=0", bus.signal_out); end
    checks++; if (bus.railed_out !== 2'b00) begin errors++; $display("FAIL mid_rst_railed got=%b exp=00", bus.railed_out); end
    checks++; if (rail_count !== 16'd0) begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", rail_count); end
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (alarm !== (k == 8)) begin errors++; $display("FAIL mid_realarm edge=%0d got=%b exp=%b", k, alarm, (k == 8)); end
    end
    checks++; if (rail_count !== 16'd1) begin errors++; $display("FAIL mid_count got=%0d exp=1", rail_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ramp();
    test_alarm();
    test_back_to_back();
    test_invalid_and_off();
    test_equal_rails();
    test_reset_mid_dwell();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
